// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the streaming popcount accumulator.
package popcount_pkg;

    // Width of a single byte's ones-count (0..8 needs 4 bits).
    localparam int BYTE_CNT_W = 4;

    // Operating mode, latched at the first beat of each frame.
    typedef enum logic {
        MODE_WORD  = 1'b0,
        MODE_FRAME = 1'b1
    } mode_e;

    // Exact width needed to hold a ones-count of a data_w-bit word (0..data_w).
    function automatic int cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/popcount_stream_acc_if.sv
// Streaming input/result bus for popcount_stream_acc.
interface popcount_stream_acc_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 16
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              mode;
    logic [ACC_W-1:0]  thresh;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_count;
    logic              out_ge;
    logic              out_sat;

    // Source/sink side: drives words in, takes results out.
    modport master (
        output in_valid, in_data, in_last, mode, thresh, out_ready,
        input  in_ready, out_valid, out_count, out_ge, out_sat
    );

    // Counter side.
    modport slave (
        input  in_valid, in_data, in_last, mode, thresh, out_ready,
        output in_ready, out_valid, out_count, out_ge, out_sat
    );

endinterface

// File: rtl/popcount_stream_acc_popcount8.sv
// Combinational ones-counter for a single byte.
module popcount8
    import popcount_pkg::*;
(
    input  logic [7:0]            data,
    output logic [BYTE_CNT_W-1:0] count
);

    // Sum the eight bits of the byte.
    always_comb begin
        count = {BYTE_CNT_W{1'b0}};
        for (int i = 0; i < 8; i++) begin
            count = count + BYTE_CNT_W'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_stream_acc.sv
// Two-stage streaming ones-counter with per-word and frame-accumulate modes.
// S1 registers per-byte counts; S2 sums them with an adder tree and either
// emits the word count or folds it into a saturating frame accumulator.
// A single global stall (result held, not taken) freezes both stages.
module popcount_stream_acc
    import popcount_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    popcount_stream_acc_if.slave bus
);

    localparam int CNT_W = cnt_w(DATA_W);
    localparam int NB    = DATA_W / 8;
    localparam int LVLS  = (NB > 1) ? $clog2(NB) : 0;
    localparam int NP    = 1 << LVLS;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    // Handshake
    logic stall_s;
    logic accept_s;
    logic out_valid_r;

    assign stall_s      = out_valid_r && !bus.out_ready;
    assign bus.in_ready = !rst && !stall_s;
    assign accept_s     = bus.in_valid && bus.in_ready;

    // Frame tracking at the input side
    logic  frame_open_r;
    mode_e mode_lat_r;
    mode_e eff_mode_s;
    logic  close_s;

    // Mode of the incoming beat: the latched mode while a frame is open,
    // otherwise the live mode input; per-word beats always close their frame.
    always_comb begin
        eff_mode_s = MODE_WORD;
        close_s    = 1'b0;
        if (frame_open_r) begin
            eff_mode_s = mode_lat_r;
        end else begin
            eff_mode_s = mode_e'(bus.mode);
        end
        if (eff_mode_s == MODE_FRAME) begin
            close_s = bus.in_last;
        end else begin
            close_s = 1'b1;
        end
    end

    // Track whether a frame is open and which mode it was opened in.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_open_r <= 1'b0;
            mode_lat_r   <= MODE_WORD;
        end else if (accept_s) begin
            frame_open_r <= !close_s;
            mode_lat_r   <= eff_mode_s;
        end
    end

    // Per-byte counters
    logic [BYTE_CNT_W-1:0] bcnt_s [NB];

    for (genvar b = 0; b < NB; b++) begin : byte_g
        popcount8 u_pc8 (
            .data  (bus.in_data[8*b +: 8]),
            .count (bcnt_s[b])
        );
    end

    // Stage 1 registers
    logic                  s1_valid_r;
    logic                  s1_close_r;
    mode_e                 s1_mode_r;
    logic [ACC_W-1:0]      s1_thresh_r;
    logic [BYTE_CNT_W-1:0] s1_bcnt_r [NB];

    // Capture byte counts and beat attributes; bubbles clear the valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_close_r  <= 1'b0;
            s1_mode_r   <= MODE_WORD;
            s1_thresh_r <= {ACC_W{1'b0}};
            for (int i = 0; i < NB; i++) begin
                s1_bcnt_r[i] <= {BYTE_CNT_W{1'b0}};
            end
        end else if (!stall_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_close_r  <= close_s;
                s1_mode_r   <= eff_mode_s;
                s1_thresh_r <= bus.thresh;
                for (int i = 0; i < NB; i++) begin
                    s1_bcnt_r[i] <= bcnt_s[i];
                end
            end
        end
    end

    // Adder tree over the byte counts, padded to a power of two
    for (genvar l = 0; l <= LVLS; l++) begin : lvl_g
        localparam int N = NP >> l;
        logic [CNT_W-1:0] node_s [N];
        for (genvar i = 0; i < N; i++) begin : node_g
            if (l == 0) begin : leaf_g
                if (i < NB) begin : used_g
                    assign node_s[i] = CNT_W'(s1_bcnt_r[i]);
                end else begin : pad_g
                    assign node_s[i] = {CNT_W{1'b0}};
                end
            end else begin : add_g
                assign node_s[i] = lvl_g[l-1].node_s[2*i] + lvl_g[l-1].node_s[2*i+1];
            end
        end
    end

    logic [CNT_W-1:0] sum_s;
    assign sum_s = lvl_g[LVLS].node_s[0];

    // Frame accumulator and saturation
    logic [ACC_W-1:0] acc_r;
    logic             sat_r;
    logic [ACC_W:0]   total_s;
    logic             ovf_s;
    logic [ACC_W-1:0] sat_total_s;
    logic             close_sat_s;

    // Add this word's count to the running total, clamping at all-ones.
    always_comb begin
        total_s     = (ACC_W+1)'(acc_r) + (ACC_W+1)'(sum_s);
        ovf_s       = total_s[ACC_W];
        sat_total_s = total_s[ACC_W-1:0];
        close_sat_s = 1'b0;
        if (ovf_s) begin
            sat_total_s = ACC_MAX;
        end else begin
            sat_total_s = total_s[ACC_W-1:0];
        end
        if (s1_mode_r == MODE_FRAME) begin
            close_sat_s = sat_r | ovf_s;
        end else begin
            close_sat_s = 1'b0;
        end
    end

    // Stage 2 / output registers
    logic [ACC_W-1:0] out_count_r;
    logic             out_ge_r;
    logic             out_sat_r;

    // Emit on closing beats, accumulate on open-frame beats, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_count_r <= {ACC_W{1'b0}};
            out_ge_r    <= 1'b0;
            out_sat_r   <= 1'b0;
            acc_r       <= {ACC_W{1'b0}};
            sat_r       <= 1'b0;
        end else if (!stall_s) begin
            if (s1_valid_r && s1_close_r) begin
                out_valid_r <= 1'b1;
                out_count_r <= sat_total_s;
                out_ge_r    <= (sat_total_s >= s1_thresh_r);
                out_sat_r   <= close_sat_s;
                acc_r       <= {ACC_W{1'b0}};
                sat_r       <= 1'b0;
            end else if (s1_valid_r) begin
                out_valid_r <= 1'b0;
                acc_r       <= sat_total_s;
                sat_r       <= sat_r | ovf_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_count = out_count_r;
    assign bus.out_ge    = out_ge_r;
    assign bus.out_sat   = out_sat_r;

endmodule

// File: tb/tb_popcount_stream_acc.sv
// Self-checking bench for popcount_stream_acc: directed scenarios plus a
// randomized run compared against a frame-level reference model.
module tb_popcount_stream_acc;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    popcount_stream_acc_if #(.DATA_W(32), .ACC_W(16)) bus_a ();
    popcount_stream_acc_if #(.DATA_W(32), .ACC_W(6))  bus_b ();

    popcount_stream_acc #(.DATA_W(32), .ACC_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    popcount_stream_acc #(.DATA_W(32), .ACC_W(6))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        int cnt;
        bit ge;
        bit sat;
        int cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    rec_t obs_b[$];
    int   acc_cyc[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rand_rdy = 1'b0;

    // Model state: is a frame open, its mode, running sum, sticky saturation
    int m_open = 0;
    int m_mode = 0;
    int m_acc  = 0;
    int m_sat  = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor + reference model, sampled on the falling edge
    initial begin
        int c;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_open = 0;
                m_acc  = 0;
                m_sat  = 0;
                while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
            end else begin
                if (bus_a.out_valid && bus_a.out_ready)
                    obs_q.push_back('{int'(bus_a.out_count), bus_a.out_ge, bus_a.out_sat, cyc});
                if (bus_b.out_valid && bus_b.out_ready)
                    obs_b.push_back('{int'(bus_b.out_count), bus_b.out_ge, bus_b.out_sat, cyc});
                if (bus_a.in_valid && bus_a.in_ready) begin
                    c = $countones(bus_a.in_data);
                    acc_cyc.push_back(cyc);
                    if (m_open == 0) begin
                        m_mode = int'(bus_a.mode);
                        m_acc  = 0;
                        m_sat  = 0;
                    end
                    if (m_mode == 0) begin
                        exp_q.push_back('{c, c >= int'(bus_a.thresh), 1'b0, 0});
                        m_open = 0;
                    end else begin
                        m_acc = m_acc + c;
                        if (m_acc > 65535) begin
                            m_acc = 65535;
                            m_sat = 1;
                        end
                        if (bus_a.in_last) begin
                            exp_q.push_back('{m_acc, m_acc >= int'(bus_a.thresh), m_sat != 0, 0});
                            m_open = 0;
                            m_acc  = 0;
                            m_sat  = 0;
                        end else begin
                            m_open = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        acc_cyc.delete();
    endtask

    // Present one beat on bus_a and hold it until accepted.
    task automatic send(input logic [31:0] d, input logic l, input logic m, input logic [15:0] t);
        int  n;
        bit  took;
        n = 0;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d;
        bus_a.in_last  = l;
        bus_a.mode     = m;
        bus_a.thresh   = t;
        forever begin
            @(negedge clk);
            took = bus_a.in_valid && bus_a.in_ready;
            @(posedge clk);
            #1;
            if (rand_rdy) bus_a.out_ready = 1'($urandom_range(0, 1));
            if (took) break;
            n++;
            if (n > 200) begin
                bad++;
                $display("FAIL send_timeout got=no_accept want=accept");
                break;
            end
        end
        bus_a.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus_a.in_valid  = 1'b0;
        rand_rdy        = 1'b0;
        bus_a.out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.in_valid = 1'b1; bus_a.in_data = 32'hFFFF_FFFF; bus_a.in_last = 1'b0;
        bus_a.mode = 1'b0; bus_a.thresh = 16'd0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b1; bus_b.in_data = 32'hFFFF_FFFF; bus_b.in_last = 1'b0;
        bus_b.mode = 1'b0; bus_b.thresh = 6'd0; bus_b.out_ready = 1'b1;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            total++;
            if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold_a got=v%b r%b want=v0 r0", bus_a.out_valid, bus_a.in_ready);
            end
            total++;
            if (bus_b.out_valid !== 1'b0 || bus_b.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold_b got=v%b r%b want=v0 r0", bus_b.out_valid, bus_b.in_ready);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_release got=v%b r%b want=v0 r1", bus_a.out_valid, bus_a.in_ready);
            end
        end
        total++;
        if (obs_q.size() !== 0 || obs_b.size() !== 0) begin
            bad++;
            $display("FAIL reset_no_output got=%0d want=0", obs_q.size() + obs_b.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_per_word();
        int ec [3] = '{32, 0, 2};
        bit eg [3] = '{1'b1, 1'b0, 1'b1};
        clear_queues();
        bus_a.out_ready = 1'b1;
        send(32'hFFFF_FFFF, 1'b0, 1'b0, 16'd2);
        send(32'h0000_0000, 1'b0, 1'b0, 16'd2);
        send(32'h8000_0001, 1'b0, 1'b0, 16'd2);
        drain();
        total++;
        if (obs_q.size() !== 3) begin
            bad++;
            $display("FAIL per_word_count got=%0d want=3", obs_q.size());
        end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i].cnt !== ec[i] || obs_q[i].ge !== eg[i] || obs_q[i].sat !== 1'b0) begin
                bad++;
                $display("FAIL per_word_value[%0d] got=%0d/%0d/%0d want=%0d/%0d/0",
                         i, obs_q[i].cnt, obs_q[i].ge, obs_q[i].sat, ec[i], eg[i]);
            end
            total++;
            if (obs_q[i].cyc !== acc_cyc[0] + 2 + i) begin
                bad++;
                $display("FAIL per_word_timing[%0d] got=%0d want=%0d", i, obs_q[i].cyc, acc_cyc[0] + 2 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [4];
        int  k;
        bit  took;
        clear_queues();
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        bus_a.out_ready = 1'b0;
        k = 0;
        bus_a.in_valid = 1'b1; bus_a.in_data = w[0]; bus_a.in_last = 1'b0;
        bus_a.mode = 1'b0; bus_a.thresh = 16'd16;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            took = bus_a.in_valid && bus_a.in_ready;
            if (i >= 2) begin
                total++;
                if (bus_a.in_ready !== 1'b0 || bus_a.out_valid !== 1'b1 ||
                    int'(bus_a.out_count) !== $countones(w[0])) begin
                    bad++;
                    $display("FAIL bp_hold got=r%b v%b c%0d want=r0 v1 c%0d",
                             bus_a.in_ready, bus_a.out_valid, bus_a.out_count, $countones(w[0]));
                end
            end
            @(posedge clk);
            #1;
            if (took) begin
                k++;
                bus_a.in_data = w[k];
            end
        end
        total++;
        if (k !== 2) begin
            bad++;
            $display("FAIL bp_accepted got=%0d want=2", k);
        end
        bus_a.out_ready = 1'b1;
        for (int i = k; i < 4; i++) send(w[i], 1'b0, 1'b0, 16'd16);
        drain();
        total++;
        if (obs_q.size() !== 4) begin
            bad++;
            $display("FAIL bp_results got=%0d want=4", obs_q.size());
        end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i].cnt !== $countones(w[i]) || obs_q[i].ge !== ($countones(w[i]) >= 16)) begin
                bad++;
                $display("FAIL bp_order[%0d] got=%0d/%0d want=%0d/%0d", i, obs_q[i].cnt, obs_q[i].ge,
                         $countones(w[i]), $countones(w[i]) >= 16);
            end
        end
    endtask

    task automatic test_frame();
        clear_queues();
        send(32'h0000_00FF, 1'b0, 1'b1, 16'd13);
        send(32'h0000_000F, 1'b0, 1'b1, 16'd13);
        send(32'h0000_0001, 1'b1, 1'b1, 16'd13);
        drain();
        total++;
        if (obs_q.size() !== 1) begin
            bad++;
            $display("FAIL frame_outputs got=%0d want=1", obs_q.size());
        end else begin
            total++;
            if (obs_q[0].cnt !== 13 || obs_q[0].ge !== 1'b1 || obs_q[0].sat !== 1'b0) begin
                bad++;
                $display("FAIL frame_value got=%0d/%0d/%0d want=13/1/0", obs_q[0].cnt, obs_q[0].ge, obs_q[0].sat);
            end
        end
    endtask

    task automatic test_saturation();
        obs_b.delete();
        bus_b.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus_b.in_valid = 1'b1;
            bus_b.in_data  = (k < 3) ? 32'hFFFF_FFFF : 32'h0000_0001;
            bus_b.in_last  = (k >= 2);
            bus_b.mode     = 1'b1;
            bus_b.thresh   = (k < 3) ? 6'd63 : 6'd2;
            @(negedge clk);
            total++;
            if (bus_b.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL sat_accept[%0d] got=%b want=1", k, bus_b.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus_b.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (obs_b.size() !== 2) begin
            bad++;
            $display("FAIL sat_outputs got=%0d want=2", obs_b.size());
        end else begin
            total++;
            if (obs_b[0].cnt !== 63 || obs_b[0].sat !== 1'b1 || obs_b[0].ge !== 1'b1) begin
                bad++;
                $display("FAIL sat_frame got=%0d/%0d/%0d want=63/1/1", obs_b[0].cnt, obs_b[0].ge, obs_b[0].sat);
            end
            total++;
            if (obs_b[1].cnt !== 1 || obs_b[1].sat !== 1'b0 || obs_b[1].ge !== 1'b0) begin
                bad++;
                $display("FAIL sat_next_frame got=%0d/%0d/%0d want=1/0/0", obs_b[1].cnt, obs_b[1].ge, obs_b[1].sat);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_queues();
        send(32'hFFFF_FFFF, 1'b0, 1'b1, 16'd1);
        send(32'h0F0F_0F0F, 1'b0, 1'b1, 16'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'h0000_0003, 1'b1, 1'b0, 16'd1);
        drain();
        total++;
        if (obs_q.size() !== 1) begin
            bad++;
            $display("FAIL rmf_outputs got=%0d want=1", obs_q.size());
        end else begin
            total++;
            if (obs_q[0].cnt !== 2 || obs_q[0].sat !== 1'b0 || obs_q[0].ge !== 1'b1) begin
                bad++;
                $display("FAIL rmf_value got=%0d/%0d/%0d want=2/1/0", obs_q[0].cnt, obs_q[0].ge, obs_q[0].sat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int          sel;
        clear_queues();
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus_a.in_valid = 1'b0;
                @(posedge clk);
                #1;
                bus_a.out_ready = 1'($urandom_range(0, 1));
            end else begin
                sel = $urandom_range(0, 7);
                if (sel == 0)      d = 32'h0000_0000;
                else if (sel == 1) d = 32'hFFFF_FFFF;
                else               d = $urandom;
                send(d, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                     16'($urandom_range(0, 120)));
            end
        end
        drain();
        total++;
        if (obs_q.size() !== exp_q.size() || exp_q.size() == 0) begin
            bad++;
            $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i].cnt !== exp_q[i].cnt || obs_q[i].ge !== exp_q[i].ge || obs_q[i].sat !== exp_q[i].sat) begin
                bad++;
                $display("FAIL rand_result[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", i,
                         obs_q[i].cnt, obs_q[i].ge, obs_q[i].sat, exp_q[i].cnt, exp_q[i].ge, exp_q[i].sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_per_word();
        test_backpressure();
        test_frame();
        test_saturation();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
